// File: rtl/bp_be_issue_queue_if.sv
// FE-to-decoder issue queue bundle: enqueue handshake, issue port, commit/roll/clear
// controls and occupancy status. The slave modport is the queue side.
interface bp_be_issue_queue_if #(
    parameter int els_p         = 8,
    parameter int vaddr_width_p = 39,
    localparam int ptr_width_lp = $clog2(els_p) + 1
);
    logic                     fe_v_i;
    logic [vaddr_width_p-1:0] fe_pc_i;
    logic [31:0]              fe_instr_i;
    logic                     fe_exc_not_instr_i;
    logic [1:0]               fe_exc_i;
    logic                     fe_ready_o;
    logic                     issue_v_o;
    logic [vaddr_width_p-1:0] issue_pc_o;
    logic [31:0]              issue_instr_o;
    logic                     issue_exc_not_instr_o;
    logic [1:0]               issue_exc_o;
    logic                     issue_yumi_i;
    logic                     commit_i;
    logic                     roll_i;
    logic                     clr_i;
    logic                     empty_o;
    logic [ptr_width_lp-1:0]  count_o;

    modport master (
        output fe_v_i, fe_pc_i, fe_instr_i, fe_exc_not_instr_i, fe_exc_i,
        output issue_yumi_i, commit_i, roll_i, clr_i,
        input  fe_ready_o, issue_v_o, issue_pc_o, issue_instr_o,
        input  issue_exc_not_instr_o, issue_exc_o, empty_o, count_o
    );

    modport slave (
        input  fe_v_i, fe_pc_i, fe_instr_i, fe_exc_not_instr_i, fe_exc_i,
        input  issue_yumi_i, commit_i, roll_i, clr_i,
        output fe_ready_o, issue_v_o, issue_pc_o, issue_instr_o,
        output issue_exc_not_instr_o, issue_exc_o, empty_o, count_o
    );
endinterface

// File: rtl/bp_be_issue_queue.sv
// Speculative issue FIFO with write/read/commit pointers; roll replays issued entries.
// Optional BP_BE_ISSUE_QUEUE_BYPASS_EN: zero-latency issue of an enqueue into an empty read side.
module bp_be_issue_queue #(
    parameter int els_p         = 8,
    parameter int vaddr_width_p = 39
) (
    input logic                clk_i,
    input logic                reset_i,
    bp_be_issue_queue_if.slave io
);
    localparam int ptr_width_lp = $clog2(els_p) + 1;
    localparam int idx_width_lp = ptr_width_lp - 1;

    logic [ptr_width_lp-1:0]  wptr_q, wptr_d, rptr_q, rptr_d, cptr_q, cptr_d;
    logic [ptr_width_lp-1:0]  cptr_adv;
    logic [vaddr_width_p-1:0] pc_mem_q    [els_p];
    logic [31:0]              instr_mem_q [els_p];
    logic                     excni_mem_q [els_p];
    logic [1:0]               exc_mem_q   [els_p];

    logic                     full, ready, enq, stored_v, bypass, issue_v;
    logic                     yumi_ok, commit_ok;
    logic [idx_width_lp-1:0]  widx, ridx;

    assign widx = wptr_q[idx_width_lp-1:0];
    assign ridx = rptr_q[idx_width_lp-1:0];

    always_comb begin
        full     = (wptr_q[idx_width_lp-1:0] == cptr_q[idx_width_lp-1:0])
                 & (wptr_q[ptr_width_lp-1] != cptr_q[ptr_width_lp-1]);
        ready    = ~full & ~io.clr_i & ~reset_i;
        enq      = io.fe_v_i & ready;
        stored_v = (rptr_q != wptr_q);
`ifdef BP_BE_ISSUE_QUEUE_BYPASS_EN
        // clr already blocks the enqueue; roll must block it explicitly
        bypass   = ~stored_v & enq & ~io.roll_i;
`else
        bypass   = 1'b0;
`endif
        issue_v  = stored_v | bypass;
    end

    always_comb begin
        io.fe_ready_o            = ready;
        io.issue_v_o             = issue_v;
        io.issue_pc_o            = pc_mem_q[ridx];
        io.issue_instr_o         = instr_mem_q[ridx];
        io.issue_exc_not_instr_o = excni_mem_q[ridx];
        io.issue_exc_o           = exc_mem_q[ridx];
        if (bypass) begin
            io.issue_pc_o            = io.fe_pc_i;
            io.issue_instr_o         = io.fe_instr_i;
            io.issue_exc_not_instr_o = io.fe_exc_not_instr_i;
            io.issue_exc_o           = io.fe_exc_i;
        end
        io.empty_o = (wptr_q == cptr_q);
        io.count_o = wptr_q - cptr_q;
    end

    always_comb begin
        yumi_ok   = io.issue_yumi_i & issue_v;
        commit_ok = io.commit_i & (cptr_q != rptr_q);
        cptr_adv  = cptr_q + ptr_width_lp'(commit_ok);
        wptr_d    = wptr_q + ptr_width_lp'(enq);
        cptr_d    = cptr_adv;
        rptr_d    = rptr_q + ptr_width_lp'(yumi_ok);
        if (io.clr_i) begin
            cptr_d = wptr_q;
            rptr_d = wptr_q;
        end else if (io.roll_i) begin
            rptr_d = cptr_adv;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cptr_q <= cptr_d;
        end
    end

    // Storage is deliberately unreset; pointers alone define validity.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            pc_mem_q[widx]    <= io.fe_pc_i;
            instr_mem_q[widx] <= io.fe_instr_i;
            excni_mem_q[widx] <= io.fe_exc_not_instr_i;
            exc_mem_q[widx]   <= io.fe_exc_i;
        end
    end

    a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i)
        io.issue_yumi_i |-> issue_v);
    a_commit_needs_issued: assert property (@(posedge clk_i) disable iff (reset_i)
        io.commit_i |-> (cptr_q != rptr_q));
endmodule

// File: tb/tb_bp_be_issue_queue.sv
// Bench for bp_be_issue_queue: queue-level reference model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_bp_be_issue_queue;
    localparam int els_lp   = 8;
    localparam int vaddr_lp = 39;
    localparam logic [1:0] e_itlb_miss = 2'd1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bp_be_issue_queue_if #(.els_p(els_lp), .vaddr_width_p(vaddr_lp)) bus ();
    bp_be_issue_queue #(.els_p(els_lp), .vaddr_width_p(vaddr_lp)) dut (
        .clk_i(clk), .reset_i(rst), .io(bus)
    );

    typedef struct packed {
        logic [vaddr_lp-1:0] pc;
        logic [31:0]         instr;
        logic                excni;
        logic [1:0]          exc;
    } ent_t;

    // Model: list of uncommitted entries, oldest first; first 'issued' are issued.
    ent_t mq[$];
    int   issued = 0;
    int   n_pass = 0;
    int   n_total = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    function automatic bit bypass_on();
`ifdef BP_BE_ISSUE_QUEUE_BYPASS_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic ent_t fe_ent();
        ent_t e;
        e.pc = bus.fe_pc_i; e.instr = bus.fe_instr_i;
        e.excni = bus.fe_exc_not_instr_i; e.exc = bus.fe_exc_i;
        return e;
    endfunction

    bit   m_ready, m_enq, m_valid;
    ent_t m_e;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            issued = 0;
        end else begin
            m_ready = (mq.size() < els_lp) && !bus.clr_i;
            m_enq   = bus.fe_v_i && m_ready;
            m_valid = (issued < mq.size()) || (bypass_on() && m_enq && !bus.roll_i);
            if (bus.clr_i) begin
                mq.delete();
                issued = 0;
            end else begin
                if (bus.commit_i && issued > 0) begin
                    void'(mq.pop_front());
                    issued--;
                end
                if (bus.roll_i) issued = 0;
                else if (bus.issue_yumi_i && m_valid) issued++;
                if (m_enq) mq.push_back(fe_ent());
            end
        end
    end

    bit   c_ready, c_v;
    ent_t c_e;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_ready", 64'(bus.fe_ready_o), 64'd0);
            chk("rst_issue_v", 64'(bus.issue_v_o), 64'd0);
            chk("rst_empty", 64'(bus.empty_o), 64'd1);
            chk("rst_count", 64'(bus.count_o), 64'd0);
        end else begin
            c_ready = (mq.size() < els_lp) && !bus.clr_i;
            c_v = 1'b0;
            c_e = '0;
            if (issued < mq.size()) begin
                c_v = 1'b1;
                c_e = mq[issued];
            end else if (bypass_on() && bus.fe_v_i && c_ready && !bus.roll_i) begin
                c_v = 1'b1;
                c_e = fe_ent();
            end
            chk("m_ready", 64'(bus.fe_ready_o), 64'(c_ready));
            chk("m_count", 64'(bus.count_o), 64'(mq.size()));
            chk("m_empty", 64'(bus.empty_o), 64'(mq.size() == 0));
            chk("m_issue_v", 64'(bus.issue_v_o), 64'(c_v));
            if (c_v) begin
                chk("m_pc", 64'(bus.issue_pc_o), 64'(c_e.pc));
                chk("m_instr", 64'(bus.issue_instr_o), 64'(c_e.instr));
                chk("m_excni", 64'(bus.issue_exc_not_instr_o), 64'(c_e.excni));
                chk("m_exc", 64'(bus.issue_exc_o), 64'(c_e.exc));
            end
        end
    end

    task automatic idle();
        bus.fe_v_i = 1'b0; bus.fe_pc_i = '0; bus.fe_instr_i = '0;
        bus.fe_exc_not_instr_i = 1'b0; bus.fe_exc_i = 2'd0;
        bus.issue_yumi_i = 1'b0; bus.commit_i = 1'b0;
        bus.roll_i = 1'b0; bus.clr_i = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1 idle();
        #1;
    endtask

    task automatic enq(input logic [vaddr_lp-1:0] pc);
        bus.fe_v_i = 1'b1;
        bus.fe_pc_i = pc;
        bus.fe_instr_i = 32'(pc) ^ 32'hA5A5_0013;
    endtask

    initial begin
        idle();
        bus.fe_v_i = 1'b1;
        #2;
        chk("reset_ready_with_fe_v", 64'(bus.fe_ready_o), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        idle();
        #1;

        // enqueue three, no yumi
        enq(39'h100);
        if (bypass_on()) begin
            #1 chk("bypass_first_v", 64'(bus.issue_v_o), 64'd1);
        end
        tick();
        chk("t1_issue_v", 64'(bus.issue_v_o), 64'd1);
        chk("t1_pc_first", 64'(bus.issue_pc_o), 64'h100);
        enq(39'h104); tick();
        enq(39'h108); tick();
        chk("t1_count", 64'(bus.count_o), 64'd3);
        chk("t1_empty", 64'(bus.empty_o), 64'd0);
        chk("t1_pc", 64'(bus.issue_pc_o), 64'h100);

        // yumi two, commit one, roll
        bus.issue_yumi_i = 1'b1; tick();
        bus.issue_yumi_i = 1'b1; tick();
        chk("t3_pc_after_yumi", 64'(bus.issue_pc_o), 64'h108);
        bus.commit_i = 1'b1; tick();
        bus.roll_i = 1'b1; tick();
        chk("t3_roll_pc", 64'(bus.issue_pc_o), 64'h104);
        chk("t3_roll_count", 64'(bus.count_o), 64'd2);

        // roll + commit + yumi together with two issued
        enq(39'h10c); tick();
        bus.issue_yumi_i = 1'b1; tick();
        bus.issue_yumi_i = 1'b1; tick();
        bus.roll_i = 1'b1; bus.commit_i = 1'b1; bus.issue_yumi_i = 1'b1; tick();
        chk("t4_pc", 64'(bus.issue_pc_o), 64'h108);
        chk("t4_count", 64'(bus.count_o), 64'd2);
        chk("t4_issue_v", 64'(bus.issue_v_o), 64'd1);

        // enqueue, yumi and commit in one cycle
        bus.issue_yumi_i = 1'b1; tick();
        enq(39'h110); bus.issue_yumi_i = 1'b1; bus.commit_i = 1'b1; tick();
        chk("mix_count", 64'(bus.count_o), 64'd2);
        chk("mix_pc", 64'(bus.issue_pc_o), 64'h110);

        // clear with five entries and a simultaneous enqueue
        enq(39'h114); tick();
        enq(39'h118); tick();
        enq(39'h11c); tick();
        chk("t5_count_before", 64'(bus.count_o), 64'd5);
        bus.clr_i = 1'b1; enq(39'h120);
        #1 chk("t5_ready_during_clr", 64'(bus.fe_ready_o), 64'd0);
        tick();
        chk("t5_empty", 64'(bus.empty_o), 64'd1);
        chk("t5_issue_v", 64'(bus.issue_v_o), 64'd0);
        chk("t5_count", 64'(bus.count_o), 64'd0);

        // fill to full, attempt overflow, commit frees a slot next cycle
        for (int i = 0; i < els_lp; i++) begin
            enq(39'h200 + 39'(4 * i));
            tick();
        end
        chk("t2_ready_full", 64'(bus.fe_ready_o), 64'd0);
        chk("t2_count_full", 64'(bus.count_o), 64'd8);
        enq(39'h300); tick();
        chk("t2_count_refused", 64'(bus.count_o), 64'd8);
        bus.issue_yumi_i = 1'b1; tick();
        bus.commit_i = 1'b1; enq(39'h304);
        #1 chk("t2_ready_commit_cycle", 64'(bus.fe_ready_o), 64'd0);
        tick();
        chk("t2_ready_after_commit", 64'(bus.fe_ready_o), 64'd1);
        chk("t2_count_after_commit", 64'(bus.count_o), 64'd7);
        bus.clr_i = 1'b1; tick();

        // exception entry
        enq(39'h400); bus.fe_exc_not_instr_i = 1'b1; bus.fe_exc_i = e_itlb_miss;
        if (bypass_on()) begin
            #1;
            chk("t6_bypass_v", 64'(bus.issue_v_o), 64'd1);
            chk("t6_bypass_excni", 64'(bus.issue_exc_not_instr_o), 64'd1);
            chk("t6_bypass_exc", 64'(bus.issue_exc_o), 64'(e_itlb_miss));
        end
        tick();
        chk("t6_issue_v", 64'(bus.issue_v_o), 64'd1);
        chk("t6_excni", 64'(bus.issue_exc_not_instr_o), 64'd1);
        chk("t6_exc", 64'(bus.issue_exc_o), 64'(e_itlb_miss));
        bus.clr_i = 1'b1; tick();

        if (bypass_on()) begin
            // bypassed entry consumed the same cycle stays rollable
            enq(39'h500); bus.issue_yumi_i = 1'b1; tick();
            chk("byp_yumi_v", 64'(bus.issue_v_o), 64'd0);
            chk("byp_yumi_count", 64'(bus.count_o), 64'd1);
            bus.roll_i = 1'b1; tick();
            chk("byp_roll_pc", 64'(bus.issue_pc_o), 64'h500);
            bus.clr_i = 1'b1; tick();
        end

        // reset in the middle of traffic discards everything
        enq(39'h600); tick();
        enq(39'h604); tick();
        enq(39'h608); rst = 1'b1;
        #1;
        chk("mrst_ready", 64'(bus.fe_ready_o), 64'd0);
        chk("mrst_count", 64'(bus.count_o), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("mrst_empty_after", 64'(bus.empty_o), 64'd1);
        chk("mrst_issue_v_after", 64'(bus.issue_v_o), 64'd0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
